// File: rtl/fx_pt_pkg.sv
// Shared fixed-point helpers: width arithmetic and rounding-mode codes.
// No ports; imported by the adder, the arbiter top and its sub-blocks.
package fx_pt_pkg;

  // Rounding-mode codes for the SN parameter of fx_pt_add_rnd
  localparam int unsigned RND_TRUNC     = 0;  // floor toward -inf
  localparam int unsigned RND_HALF_UP   = 1;  // nearest, ties toward +inf
  localparam int unsigned RND_HALF_EVEN = 2;  // nearest, ties to even
  localparam int unsigned RND_HALF_AWAY = 3;  // nearest, ties away from zero

  // Total word width of a fixed-point format
  function automatic int unsigned fx_w(input int unsigned iw, input int unsigned fw);
    return iw + fw;
  endfunction

  function automatic int unsigned fx_max(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  // Bits needed to encode n distinct values (minimum 1)
  function automatic int unsigned fx_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fx_pt_add_arb_rr_arb.sv
// Round-robin priority search: first set req bit at or after ptr, wrapping.
// Ports: req (request vector), ptr (search start), grant_c (one-hot winner),
//        idx_c (encoded winner), any_c (some request present).
module rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  int unsigned j;

  // Walk NREQ positions from ptr; the first hit wins and later hits are masked
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr) + i) % NREQ;
      if (!any_c && req[IDW'(j)]) begin
        any_c              = 1'b1;
        grant_c[IDW'(j)]   = 1'b1;
        idx_c              = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fx_pt_add_rnd.sv
// Combinational fixed-point adder with rounding to SFW fraction bits.
// Ports: a (AIW.AFW signed), b (BIW.BFW signed), sum_c (SIW.SFW signed).
module fx_pt_add_rnd
  import fx_pt_pkg::*;
#(
  parameter int unsigned SN  = RND_HALF_EVEN,
  parameter int unsigned AIW = 11,
  parameter int unsigned AFW = 9,
  parameter int unsigned BIW = 8,
  parameter int unsigned BFW = 10,
  parameter int unsigned SIW = fx_max(AIW, BIW) + 2,
  parameter int unsigned SFW = 8
) (
  input  logic [AIW+AFW-1:0] a,
  input  logic [BIW+BFW-1:0] b,
  output logic [SIW+SFW-1:0] sum_c
);

  localparam int unsigned SW = fx_w(SIW, SFW);
  localparam int unsigned FW = fx_max(fx_max(AFW, BFW), SFW);
  localparam int unsigned TW = SIW + FW;
  localparam int unsigned DW = FW - SFW;

  logic [TW-1:0] a_ext;
  logic [TW-1:0] b_ext;
  logic [TW-1:0] full;

  // Sign-extend to SIW integer bits and align both binary points at FW
  assign a_ext = TW'($signed(a)) << (FW - AFW);
  assign b_ext = TW'($signed(b)) << (FW - BFW);
  assign full  = a_ext + b_ext;

  if (DW == 0) begin : g_exact
    assign sum_c = full;
  end else begin : g_rnd
    logic [SW-1:0] keep;
    logic [DW-1:0] rem;
    logic          rbit;
    logic          sticky;
    logic          inc;

    // keep is the floor of the sum at SFW; rem is the discarded tail
    assign keep   = full[TW-1:DW];
    assign rem    = full[DW-1:0];
    assign rbit   = rem[DW-1];
    assign sticky = (rem & ~(DW'(1) << (DW - 1))) != '0;

    always_comb begin
      inc = 1'b0;
      if (SN == RND_HALF_UP) begin
        inc = rbit;
      end else if (SN == RND_HALF_EVEN) begin
        inc = rbit & (sticky | keep[0]);
      end else if (SN == RND_HALF_AWAY) begin
        // A negative exact tie already sits away from zero after the floor
        inc = rbit & (sticky | ~full[TW-1]);
      end
    end

    assign sum_c = keep + SW'(inc);
  end

endmodule

// File: rtl/fx_pt_add_arb.sv
// Round-robin shared fixed-point adder: arbitrate NREQ operand requesters,
// register the winner's pair (stage 1), register the rounded sum (stage 2).
// Ports: clk, rst (async active-low), req_valid/req_ready/req_a/req_b
//        (per-requester operand handshake), rsp_valid/rsp_ready/rsp_sum/rsp_id
//        (tagged result handshake), busy (any item in flight).
module fx_pt_add_arb
  import fx_pt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = fx_clog2(NREQ),
  parameter int unsigned SN   = RND_HALF_EVEN,
  parameter int unsigned AIW  = 11,
  parameter int unsigned AFW  = 9,
  parameter int unsigned BIW  = 8,
  parameter int unsigned BFW  = 10,
  parameter int unsigned SIW  = fx_max(AIW, BIW) + 2,
  parameter int unsigned SFW  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*(AIW+AFW)-1:0]   req_a,
  input  logic [NREQ*(BIW+BFW)-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [SIW+SFW-1:0]          rsp_sum,
  output logic [IDW-1:0]              rsp_id,
  output logic                        busy
);

  localparam int unsigned AW = fx_w(AIW, AFW);
  localparam int unsigned BW = fx_w(BIW, BFW);
  localparam int unsigned SW = fx_w(SIW, SFW);

  logic [IDW-1:0]  rr_ptr;
  logic            s1_v;
  logic [AW-1:0]   s1_a;
  logic [BW-1:0]   s1_b;
  logic [IDW-1:0]  s1_id;

  logic            s1_en;
  logic            s2_en;
  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic [AW-1:0]   sel_a;
  logic [BW-1:0]   sel_b;
  logic [SW-1:0]   add_sum;

  // Stage 2 advances when empty or drained; stage 1 when empty or stage 2 advances
  assign s2_en = ~rsp_valid | rsp_ready;
  assign s1_en = ~s1_v | s2_en;

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant_c (arb_grant),
    .idx_c   (arb_idx),
    .any_c   (arb_any)
  );

  assign req_ready = s1_en ? arb_grant : '0;
  assign busy      = s1_v | rsp_valid;

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_a = req_a[i*AW +: AW];
        sel_b = req_b[i*BW +: BW];
      end
    end
  end

  fx_pt_add_rnd #(
    .SN  (SN),
    .AIW (AIW),
    .AFW (AFW),
    .BIW (BIW),
    .BFW (BFW),
    .SIW (SIW),
    .SFW (SFW)
  ) u_add (
    .a     (s1_a),
    .b     (s1_b),
    .sum_c (add_sum)
  );

  // Stage 1: capture the granted pair and advance the round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
      rr_ptr <= '0;
    end else if (s1_en) begin
      if (arb_any) begin
        s1_v  <= 1'b1;
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= arb_idx;
        if (arb_idx == IDW'(NREQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= arb_idx + IDW'(1);
        end
      end else begin
        s1_v <= 1'b0;
      end
    end
  end

  // Stage 2: register the rounded sum and its requester tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (s2_en) begin
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_sum <= add_sum;
        rsp_id  <= s1_id;
      end
    end
  end

endmodule

// File: doc/fx_pt_add_arb.md
Name: fx_pt_add_arb

Overview:
Round-robin arbiter and 2-stage pipeline controller that shares one fixed-point round-adder datapath (fx_pt_add_rnd) among NREQ requesters. Each requester offers an (a, b) operand pair over a valid/ready handshake. The block grants one requester per cycle, registers the operands, and registers the rounded sum. It returns the sum tagged with the requester id over a back-pressurable response port. It sits between producer blocks and the shared adder, replacing per-client adder instances.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equals clog2(NREQ)
SN, 2, rounding mode, passed unchanged to the adder
AIW, 11, operand A integer bits (signed two's complement)
AFW, 9, operand A fraction bits
BIW, 8, operand B integer bits
BFW, 10, operand B fraction bits
SIW, max(AIW,BIW)+2, sum integer bits
SFW, 8, sum fraction bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  NREQ*(AIW+AFW)  operand A; slice i belongs to requester i
req_b  in  NREQ*(BIW+BFW)  operand B; slice i belongs to requester i
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_sum  out  SIW+SFW  rounded sum of accepted pair
rsp_id  out  IDW  requester index of rsp_sum
busy  out  1  s1_v | rsp_valid

Behaviour:
- Reset (rst=0, asynchronous): s1_v=0, rsp_valid=0, rsp_sum=0, rsp_id=0, s1 operand/id regs=0, rr_ptr=0. Reset mid-operation discards all in-flight work; no response is emitted for it.
- Stage enables: s2_en = !rsp_valid | rsp_ready. s1_en = !s1_v | s2_en.
- Arbitration (combinational): search req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit k is the winner.
- req_ready[k] = s1_en & req_valid[k]. All other req_ready bits are 0. req_ready is 0 everywhere when no req_valid is set. Requesters must not gate req_valid on req_ready.
- Acceptance at an edge (req_valid[k] & req_ready[k]):
  - s1_a <= slice k of req_a; s1_b <= slice k of req_b; s1_id <= k; s1_v <= 1.
  - rr_ptr <= (k+1) mod NREQ.
- No acceptance while s1_en=1: s1_v <= 0, rr_ptr holds.
- Stage 2: the adder is combinational on s1_a/s1_b. When s2_en: rsp_valid <= s1_v; if s1_v then rsp_sum <= adder sum and rsp_id <= s1_id.
- When s2_en=0: s1 and s2 hold. rsp_sum and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Latency: acceptance at edge T gives rsp_valid=1 after edge T+1 (2 registers). Throughput is 1 result per cycle with rsp_ready=1.
- Responses are delivered in acceptance order. No loss or duplication under any stall pattern.
- Maximum in-flight items is 2. With rsp_ready=0 for at least 2 cycles, req_ready is all-zero.
- Arithmetic:
  - Operands are aligned on the binary point and sign-extended to SIW integer bits.
  - The sum is rounded to SFW per SN; the result is bit-exact with fx_pt_add_rnd.
  - SIW = max+2 guarantees no overflow; no saturation logic is present.
- Pointer wrap: after requester NREQ-1 is served, rr_ptr=0.
- Simultaneous events:
  - Acceptance into s1 and a response handshake in the same cycle are legal and required for full throughput.
  - A requester dropping req_valid without a handshake is ignored.

Decomposition:
- Shared package fx_pt_pkg:
  - width helper functions: AW=AIW+AFW, BW=BIW+BFW, SW=SIW+SFW, clog2.
  - SN rounding-mode constants.
- Sub-module rr_arb (NREQ): inputs req, ptr; outputs one-hot grant and encoded index.
- Adder datapath: one fx_pt_add_rnd instance, all width parameters passed through.
- Top level holds the stage registers, enables and rr_ptr.

Test Plan:
1. Basic sum. Requester 0 only, a=20'h00300 (+1.5), b=18'h00900 (+2.25), rsp_ready=1 → rsp_valid two edges later, rsp_sum=21'h003C0 (+3.75), rsp_id=0.
2. Sign handling. Requester 2: a=20'hFFE00 (-1.0), b=18'h00200 (+0.5) → rsp_sum=21'h1FFF80 (-0.5), rsp_id=2.
3. Full contention. All 4 requesters valid every cycle, rsp_ready=1 → grants 0,1,2,3,0,1… one per cycle; rsp_id follows the same order; each sum matches the golden model.
4. Back-pressure. All valid, rsp_ready=0 for 6 cycles → exactly 2 acceptances then req_ready=0, rsp_sum/rsp_id stable. On release, ids continue in round-robin order with no gap or duplicate.
5. Sparse fairness. Only req 1 and 3 valid, rr_ptr=0 → 1,3,1,3…; after 3 is served, rr_ptr wraps to 0 and req 1 wins next.
6. Reset mid-flight. s1 and s2 both full, rst pulsed low → rsp_valid=0 and busy=0 immediately. After release, with all valid, the first grant is req 0; the pre-reset pairs never appear on rsp.
